// File: rtl/crc_stream_engine.sv
// Streaming CRC checker: each accepted word is shifted MSB-first through the CRC
// register BPC bits per clock; at end of frame the result is published and compared.
module crc_stream_engine #(
  parameter int               DATA_W  = 32,
  parameter int               CRC_W   = 10,
  parameter logic [CRC_W-1:0] POLY    = 10'h233,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int               BPC     = 1
) (
  input  logic              Clock,
  input  logic              Rst_n,
  input  logic              CRC_Clr,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Sof,
  input  logic              Eof,
  input  logic [CRC_W-1:0]  Exp_CRC,
  output logic [CRC_W-1:0]  CRC_Out,
  output logic              CRC_Valid,
  output logic              CRC_Err
);

  localparam int STEPS = DATA_W / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  sbuf;
  logic [CRC_W-1:0]   crc, crc_step, exp_q;
  logic [CNT_W-1:0]   cnt;
  logic               eof_q, accept, last;

  always_ff @(posedge Clock) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Ready is withheld during reset and abort so nothing slips in on those edges.
  always_comb begin
    state_nxt = state;
    In_Ready  = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        In_Ready = Rst_n && !CRC_Clr;
        accept   = In_Valid && Rst_n && !CRC_Clr;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        last = (cnt == CNT_W'(STEPS - 1));
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (CRC_Clr) state_nxt = IDLE;
  end

  always_comb begin
    crc_step = crc;
    for (int i = 0; i < BPC; i++)
      crc_step = {crc_step[CRC_W-2:0], 1'b0} ^
                 ({CRC_W{crc_step[CRC_W-1] ^ sbuf[DATA_W-1-i]}} & POLY);
  end

  always_ff @(posedge Clock) begin
    if (!Rst_n) begin
      crc       <= INIT;
      sbuf      <= '0;
      exp_q     <= '0;
      eof_q     <= 1'b0;
      cnt       <= '0;
      CRC_Out   <= '0;
      CRC_Valid <= 1'b0;
      CRC_Err   <= 1'b0;
    end else begin
      CRC_Valid <= 1'b0;
      if (CRC_Clr) begin
        crc <= INIT;
        cnt <= '0;
      end else if (accept) begin
        sbuf  <= Data_In;
        eof_q <= Eof;
        exp_q <= Exp_CRC;
        cnt   <= '0;
        if (Sof) crc <= INIT;
      end else if (state == SHIFT) begin
        crc  <= crc_step;
        sbuf <= sbuf << BPC;
        cnt  <= cnt + 1'b1;
        // Final bits of an Eof word: publish and re-arm for the next frame.
        if (last && eof_q) begin
          CRC_Out   <= crc_step ^ XOR_OUT;
          CRC_Err   <= (crc_step ^ XOR_OUT) != exp_q;
          CRC_Valid <= 1'b1;
          crc       <= INIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomized self-checking bench for crc_stream_engine: a default 32/10 instance
// plus CRC-16/CCITT byte instances at two bits-per-clock settings.
module tb_crc_stream_engine;

  logic        Clock = 1'b0;
  logic        Rst_n, CRC_Clr, In_Valid, Sof, Eof, In_Ready, CRC_Valid, CRC_Err;
  logic [31:0] Data_In;
  logic [9:0]  Exp_CRC, CRC_Out;

  logic        b_clr, b_sof, b_eof, b2_vin, b8_vin;
  logic [7:0]  b_din;
  logic [15:0] b_exp, b2_out, b8_out;
  logic        b2_ready, b2_valid, b2_err, b8_ready, b8_valid, b8_err;

  int vectors = 0;
  int errors  = 0;
  int pcyc    = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) pcyc <= pcyc + 1;

  crc_stream_engine dut (
    .Clock(Clock), .Rst_n(Rst_n), .CRC_Clr(CRC_Clr), .Data_In(Data_In),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .Sof(Sof), .Eof(Eof),
    .Exp_CRC(Exp_CRC), .CRC_Out(CRC_Out), .CRC_Valid(CRC_Valid), .CRC_Err(CRC_Err)
  );

  crc_stream_engine #(.DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .BPC(2)) dut_b2 (
    .Clock(Clock), .Rst_n(Rst_n), .CRC_Clr(b_clr), .Data_In(b_din),
    .In_Valid(b2_vin), .In_Ready(b2_ready), .Sof(b_sof), .Eof(b_eof),
    .Exp_CRC(b_exp), .CRC_Out(b2_out), .CRC_Valid(b2_valid), .CRC_Err(b2_err)
  );

  crc_stream_engine #(.DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .BPC(8)) dut_b8 (
    .Clock(Clock), .Rst_n(Rst_n), .CRC_Clr(b_clr), .Data_In(b_din),
    .In_Valid(b8_vin), .In_Ready(b8_ready), .Sof(b_sof), .Eof(b_eof),
    .Exp_CRC(b_exp), .CRC_Out(b8_out), .CRC_Valid(b8_valid), .CRC_Err(b8_err)
  );

  // Reference: polynomial division of the whole frame's bit stream, MSB of each word first.
  function automatic logic [31:0] ref_crc(input logic [31:0] words[$], input int dw, input int w,
                                          input logic [31:0] poly, input logic [31:0] init,
                                          input logic [31:0] xo);
    logic [31:0] r    = init;
    logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    foreach (words[k])
      for (int b = dw - 1; b >= 0; b--) begin
        logic top = r[w-1];
        r = (r << 1) & mask;
        if (top ^ words[k][b]) r = r ^ poly;
      end
    return (r ^ xo) & mask;
  endfunction

  task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [9:0] x,
                      output int acc);
    int t = 0;
    Data_In = d; Sof = s; Eof = e; Exp_CRC = x;
    while (!In_Ready && t < 200) begin @(negedge Clock); t++; end
    if (t >= 200) begin
      vectors++; errors++;
      $display("FAIL send_ready_timeout: In_Ready stayed %b, want 1", In_Ready);
    end
    In_Valid = 1'b1;
    acc = pcyc;
    @(negedge Clock);
    In_Valid = 1'b0;
    Data_In = $urandom; Sof = 1'($urandom); Eof = 1'($urandom); Exp_CRC = 10'($urandom);
  endtask

  task automatic wait_valid(output int at);
    int t = 0;
    while (!CRC_Valid && t < 200) begin @(negedge Clock); t++; end
    if (t >= 200) begin
      vectors++; errors++;
      $display("FAIL valid_timeout: CRC_Valid stayed %b, want 1", CRC_Valid);
    end
    at = pcyc;
  endtask

  task automatic expect_no_valid(input int n, input string name);
    logic seen = 1'b0;
    repeat (n) begin @(negedge Clock); if (CRC_Valid) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin errors++; $display("FAIL %s: CRC_Valid pulse seen, want none", name); end
  endtask

  task automatic check_frame(input string name, input logic [9:0] want, input logic want_err);
    vectors++;
    if (CRC_Out !== want) begin errors++; $display("FAIL %s_out: got %h want %h", name, CRC_Out, want); end
    vectors++;
    if (CRC_Err !== want_err) begin errors++; $display("FAIL %s_err: got %b want %b", name, CRC_Err, want_err); end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; CRC_Clr = 1'b0; In_Valid = 1'b0; Sof = 1'b0; Eof = 1'b0;
    Data_In = '0; Exp_CRC = '0;
    b_clr = 1'b0; b_sof = 1'b0; b_eof = 1'b0; b2_vin = 1'b0; b8_vin = 1'b0; b_din = '0; b_exp = '0;
    repeat (3) @(negedge Clock);
    vectors++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", In_Ready); end
    vectors++; if (CRC_Out !== 10'h0) begin errors++; $display("FAIL rst_out: got %h want 000", CRC_Out); end
    vectors++; if (CRC_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", CRC_Valid); end
    vectors++; if (CRC_Err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", CRC_Err); end
    Rst_n = 1'b1;
    @(negedge Clock);
    vectors++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", In_Ready); end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int vcyc = -1;
    int t = 0;
    int at;
    Data_In = 32'h1; Sof = 1'b1; Eof = 1'b1; Exp_CRC = 10'h233;
    In_Valid = 1'b1;
    while (acc.size() < 3 && t < 300) begin
      if (In_Ready) acc.push_back(pcyc);
      if (CRC_Valid && vcyc < 0) begin vcyc = pcyc; check_frame("b2b_first", 10'h233, 1'b0); end
      @(negedge Clock); t++;
    end
    In_Valid = 1'b0;
    vectors++;
    if (acc.size() < 3) begin
      errors++; $display("FAIL b2b_accepts: got %0d accepts want 3", acc.size());
    end else begin
      if (acc[1] - acc[0] != 33) begin errors++; $display("FAIL b2b_spacing1: got %0d want 33", acc[1] - acc[0]); end
      vectors++;
      if (acc[2] - acc[1] != 33) begin errors++; $display("FAIL b2b_spacing2: got %0d want 33", acc[2] - acc[1]); end
      vectors++;
      if (vcyc - acc[0] != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", vcyc - acc[0]); end
    end
    wait_valid(at);
    check_frame("b2b_last", 10'h233, 1'b0);
    @(negedge Clock);
  endtask

  task automatic test_random_frames;
    for (int f = 0; f < 12; f++) begin
      logic [31:0] words[$];
      int          n = $urandom_range(1, 4);
      logic [9:0]  want, exp;
      int          acc, at;
      for (int k = 0; k < n; k++) words.push_back($urandom);
      want = 10'(ref_crc(words, 32, 10, 32'h233, 32'h0, 32'h0));
      exp  = ($urandom % 2) ? want : 10'($urandom);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge Clock);
        send(words[k], (k == 0) ? 1'($urandom) : 1'b0, k == n - 1, exp, acc);
      end
      wait_valid(at);
      check_frame("rand_frame", want, want != exp);
    end
  endtask

  task automatic test_sof_restart;
    int acc, at;
    send(32'hFFFF_FFFF, 1'b1, 1'b0, 10'h0, acc);
    expect_no_valid(34, "sof_restart_open");
    send(32'h0000_0001, 1'b1, 1'b1, 10'h233, acc);
    wait_valid(at);
    check_frame("sof_restart", 10'h233, 1'b0);
    expect_no_valid(5, "sof_restart_single");
  endtask

  task automatic test_clear;
    logic [31:0] w[$];
    logic [9:0]  k;
    int          acc, at;
    w.push_back($urandom);
    k = 10'(ref_crc(w, 32, 10, 32'h233, 32'h0, 32'h0));
    send(w[0], 1'b1, 1'b1, k, acc);
    wait_valid(at);
    check_frame("clr_pre", k, 1'b0);
    send($urandom, 1'b1, 1'b1, 10'h0, acc);
    repeat (9) @(negedge Clock);
    CRC_Clr = 1'b1;
    @(negedge Clock);
    CRC_Clr = 1'b0;
    #1;
    vectors++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", In_Ready); end
    expect_no_valid(40, "clr_suppress");
    check_frame("clr_hold", k, 1'b0);
    send(32'h1, 1'b1, 1'b1, 10'h233, acc);
    wait_valid(at);
    check_frame("clr_after", 10'h233, 1'b0);
  endtask

  task automatic test_reset_mid;
    int acc, at;
    send(32'h1, 1'b1, 1'b1, 10'h0, acc);
    repeat (5) @(negedge Clock);
    Rst_n = 1'b0;
    #1;
    vectors++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", In_Ready); end
    @(negedge Clock);
    vectors++; if (CRC_Out !== 10'h0) begin errors++; $display("FAIL midrst_out: got %h want 000", CRC_Out); end
    vectors++; if (CRC_Valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", CRC_Valid); end
    vectors++; if (CRC_Err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", CRC_Err); end
    Rst_n = 1'b1;
    expect_no_valid(40, "midrst_abort");
    send(32'h1, 1'b1, 1'b1, 10'h000, acc);
    wait_valid(at);
    check_frame("midrst_err_frame", 10'h233, 1'b1);
  endtask

  task automatic send_b(input int sel, input logic [7:0] d, input logic s, input logic e,
                        input logic [15:0] x, output int acc);
    int t = 0;
    b_din = d; b_sof = s; b_eof = e; b_exp = x;
    while (!(sel == 2 ? b2_ready : b8_ready) && t < 100) begin @(negedge Clock); t++; end
    if (t >= 100) begin vectors++; errors++; $display("FAIL b%0d_ready_timeout: still busy, want ready", sel); end
    if (sel == 2) b2_vin = 1'b1; else b8_vin = 1'b1;
    acc = pcyc;
    @(negedge Clock);
    b2_vin = 1'b0; b8_vin = 1'b0;
    b_din = 8'($urandom); b_sof = 1'($urandom); b_eof = 1'($urandom);
  endtask

  task automatic run_b_frame(input int sel, input logic [31:0] bytes[$], input logic [15:0] exp,
                             input logic [15:0] want, input string name);
    int acc = 0, t = 0, n = bytes.size();
    int steps = (sel == 2) ? 4 : 1;
    for (int k = 0; k < n; k++) send_b(sel, bytes[k][7:0], k == 0, k == n - 1, exp, acc);
    while (!(sel == 2 ? b2_valid : b8_valid) && t < 100) begin @(negedge Clock); t++; end
    vectors++;
    if (pcyc - acc != steps + 1) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, pcyc - acc, steps + 1); end
    vectors++;
    if ((sel == 2 ? b2_out : b8_out) !== want) begin
      errors++; $display("FAIL %s_out: got %h want %h", name, (sel == 2 ? b2_out : b8_out), want);
    end
    vectors++;
    if ((sel == 2 ? b2_err : b8_err) !== (want != exp)) begin
      errors++; $display("FAIL %s_err: got %b want %b", name, (sel == 2 ? b2_err : b8_err), want != exp);
    end
  endtask

  task automatic test_crc16;
    logic [31:0] chk[$];
    for (int c = 0; c < 9; c++) chk.push_back(32'h31 + c);
    run_b_frame(2, chk, 16'h29B1, 16'h29B1, "ccitt_bpc2");
    run_b_frame(8, chk, 16'h29B1, 16'h29B1, "ccitt_bpc8");
    for (int f = 0; f < 4; f++) begin
      logic [31:0] bytes[$];
      logic [15:0] want, exp;
      int          n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) bytes.push_back(32'($urandom_range(0, 255)));
      want = 16'(ref_crc(bytes, 8, 16, 32'h1021, 32'hFFFF, 32'h0));
      exp  = (f % 2) ? want : 16'($urandom);
      run_b_frame(2, bytes, exp, want, "rand16_bpc2");
      run_b_frame(8, bytes, exp, want, "rand16_bpc8");
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_random_frames;
    test_sof_restart;
    test_clear;
    test_reset_mid;
    test_crc16;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, giving the input word width in bits.
REQ-002 The block SHALL have the parameter CRC_W, default 10, giving the CRC width in bits.
REQ-003 The block SHALL have the parameter POLY, default 10'h233 (x^10+x^9+x^5+x^4+x+1), giving the generator polynomial without the x^CRC_W term.
REQ-004 The block SHALL have the parameter INIT, default 0, giving the register preset at frame start.
REQ-005 The block SHALL have the parameter XOR_OUT, default 0, XORed onto the final remainder.
REQ-006 The block SHALL have the parameter BPC, default 1, giving the bits processed per clock; DATA_W SHALL be an integer multiple of BPC.
REQ-007 The block SHALL have the port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have the port Rst_n, input, 1 bit: synchronous active-low reset.
REQ-009 The block SHALL have the port CRC_Clr, input, 1 bit: synchronous frame abort.
REQ-010 The block SHALL have the port Data_In, input, DATA_W bits: input word, MSB processed first.
REQ-011 The block SHALL have the port In_Valid, input, 1 bit: Data_In, Sof, Eof and Exp_CRC are valid.
REQ-012 The block SHALL have the port In_Ready, output, 1 bit: the block accepts a word this cycle.
REQ-013 The block SHALL have the port Sof, input, 1 bit: the word is the first of a frame.
REQ-014 The block SHALL have the port Eof, input, 1 bit: the word is the last of a frame.
REQ-015 The block SHALL have the port Exp_CRC, input, CRC_W bits: expected CRC, sampled with the Eof word.
REQ-016 The block SHALL have the port CRC_Out, output, CRC_W bits: final CRC of the last completed frame.
REQ-017 The block SHALL have the port CRC_Valid, output, 1 bit: one-cycle pulse, CRC_Out updated.
REQ-018 The block SHALL have the port CRC_Err, output, 1 bit: CRC_Out != Exp_CRC; valid with CRC_Valid.

Function
REQ-019 A word SHALL be accepted only in a cycle with In_Valid=1 and In_Ready=1.
REQ-020 The block SHALL use a two-state FSM: IDLE (In_Ready=1) and SHIFT (In_Ready=0).
REQ-021 On accept, the FSM SHALL go IDLE->SHIFT, latch Data_In into a shift buffer, and latch Eof and Exp_CRC.
REQ-022 On an accept with Sof=1, the CRC register SHALL be loaded with INIT before the word's first bit is processed.
REQ-023 On an accept with Sof=0, the block SHALL continue from the current register value, which is INIT after reset or abort.
REQ-024 The per-bit update SHALL be: fb = crc[CRC_W-1] ^ din; crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_W bits (non-augmented, non-reflected).
REQ-025 In SHIFT, each cycle SHALL process the next BPC bits MSB-first, so a word takes exactly DATA_W/BPC cycles.
REQ-026 After the last SHIFT cycle, the FSM SHALL return to IDLE, giving one word accepted per DATA_W/BPC+1 cycles.
REQ-027 When the latched Eof=1, in the cycle after the last SHIFT cycle: CRC_Out = crc ^ XOR_OUT, CRC_Err = (crc ^ XOR_OUT) != latched Exp_CRC, and CRC_Valid=1 for exactly one cycle.
REQ-028 After an Eof word, the CRC register SHALL reload INIT.
REQ-029 CRC_Out and CRC_Err SHALL hold their values until the next CRC_Valid.
REQ-030 Sof and Eof asserted on the same word SHALL form a single-word frame.
REQ-031 Sof=1 on a word while a frame is open SHALL discard the open frame's partial CRC without a CRC_Valid.
REQ-032 CRC_Clr=1 SHALL immediately force IDLE and set crc=INIT, suppressing any pending CRC_Valid; it SHALL NOT change CRC_Out or CRC_Err, and no word SHALL be accepted in that cycle.
REQ-033 While In_Ready=0, Data_In, Sof, Eof and Exp_CRC SHALL be ignored.

Reset
REQ-034 With Rst_n=0 at a rising Clock edge: FSM=IDLE, crc=INIT, CRC_Out=0, CRC_Valid=0, CRC_Err=0, and the shift buffer and latches are cleared.
REQ-035 Rst_n SHALL take priority over CRC_Clr and In_Valid, and SHALL abort any frame, including one mid-SHIFT.
REQ-036 In_Ready SHALL be 0 while Rst_n=0 and 1 in the first cycle after release.

Verification
REQ-037 Defaults, Sof=Eof=1, Data_In=32'h0000_0001, Exp_CRC=10'h233 -> after 32 SHIFT cycles, CRC_Valid pulse, CRC_Out=10'h233, CRC_Err=0; In_Valid=1 held continuously -> next accept exactly 33 cycles after the first.
REQ-038 DATA_W=8, CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, BPC=8, bytes "123456789" (Sof on first byte, Eof on last) -> CRC_Out=16'h29B1; same run with BPC=1 or 2 -> identical result, 8 and 4 SHIFT cycles per byte respectively.
REQ-039 Defaults, frame of Sof 32'hFFFF_FFFF then Sof=Eof 32'h0000_0001 -> first frame discarded, single CRC_Valid, CRC_Out=10'h233.
REQ-040 Defaults, CRC_Clr pulse in the 10th SHIFT cycle of an Eof word -> no CRC_Valid, In_Ready=1 next cycle, CRC_Out unchanged; a following 32'h1 single-word frame -> 10'h233.
REQ-041 Defaults, Rst_n=0 mid-SHIFT -> all outputs at reset values next cycle; Exp_CRC=10'h000 with Data_In=32'h1 -> CRC_Err=1.
